// File: rtl/genius_pixel_gen_pkg.sv
// Shared constants for the Genius pad display: pad indices, colours, screen split and FSM encoding.
package genius_pixel_gen_pkg;

   localparam logic [1:0] PadGreen  = 2'd0;
   localparam logic [1:0] PadRed    = 2'd1;
   localparam logic [1:0] PadYellow = 2'd2;
   localparam logic [1:0] PadBlue   = 2'd3;

   localparam logic [23:0] BrightGreen  = 24'h00FF00;
   localparam logic [23:0] BrightRed    = 24'hFF0000;
   localparam logic [23:0] BrightYellow = 24'hFFFF00;
   localparam logic [23:0] BrightBlue   = 24'h0000FF;
   localparam logic [23:0] DimGreen     = 24'h004000;
   localparam logic [23:0] DimRed       = 24'h400000;
   localparam logic [23:0] DimYellow    = 24'h404000;
   localparam logic [23:0] DimBlue      = 24'h000040;

   localparam int unsigned SplitX      = 320;
   localparam int unsigned SplitY      = 240;
   localparam int unsigned DividerHalf = 2;

   typedef enum logic [1:0] {StIdle, StArmed, StLit, StDone} light_state_e;

   function automatic logic [23:0] pad_rgb(input logic [1:0] pad, input logic bright);
      logic [23:0] rgb;
      unique case (pad)
         PadGreen:  rgb = bright ? BrightGreen  : DimGreen;
         PadRed:    rgb = bright ? BrightRed    : DimRed;
         PadYellow: rgb = bright ? BrightYellow : DimYellow;
         default:   rgb = bright ? BrightBlue   : DimBlue;
      endcase
      return rgb;
   endfunction

endpackage

// File: rtl/genius_light_fsm.sv
// Pad-lighting request FSM: accepts one request in idle, lights it for N frames aligned to
// frame starts, then pulses done.
module genius_light_fsm
   import genius_pixel_gen_pkg::*;
(
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       frame_start_i,
   input  logic       light_req_i,
   input  logic [1:0] light_color_i,
   input  logic [5:0] light_frames_i,
   output logic       lit_en_o,
   output logic [1:0] lit_pad_o,
   output logic       busy_o,
   output logic       done_o
);

   light_state_e state_q, state_d;
   logic [1:0]   pad_q, pad_d;
   logic [5:0]   cnt_q, cnt_d;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= StIdle;
         pad_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pad_q   <= pad_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pad_d   = pad_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (light_req_i) begin
               pad_d   = light_color_i;
               cnt_d   = (light_frames_i == '0) ? 6'd1 : light_frames_i;
               state_d = StArmed;
            end
         end
         StArmed: begin
            if (frame_start_i) state_d = StLit;
         end
         StLit: begin
            // The frame start that sees a count of 1 closes the final lit frame.
            if (frame_start_i) begin
               if (cnt_q == 6'd1) state_d = StDone;
               else               cnt_d   = cnt_q - 6'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      lit_en_o  = (state_q == StLit);
      lit_pad_o = pad_q;
      busy_o    = (state_q != StIdle);
      done_o    = (state_q == StDone);
   end

endmodule

// File: rtl/genius_pixel_gen.sv
// Genius game pixel generator: four coloured quadrant pads with a black divider cross; one pad
// can be lit bright for a number of frames on request.
module genius_pixel_gen
   import genius_pixel_gen_pkg::*;
(
   input  logic       VGA_CLK,
   input  logic       reset,
   input  logic       VGA_HS,
   input  logic       VGA_VS,
   input  logic       VGA_BLANK_N,
   input  logic       light_req,
   input  logic [1:0] light_color,
   input  logic [5:0] light_frames,
   output logic [7:0] R,
   output logic [7:0] G,
   output logic [7:0] B,
   output logic       light_busy,
   output logic       light_done
);

   localparam logic [9:0] SplitXW = 10'(SplitX);
   localparam logic [8:0] SplitYW = 9'(SplitY);
   localparam logic [9:0] DivXLo  = 10'(SplitX - DividerHalf);
   localparam logic [9:0] DivXHi  = 10'(SplitX + DividerHalf - 1);
   localparam logic [8:0] DivYLo  = 9'(SplitY - DividerHalf);
   localparam logic [8:0] DivYHi  = 9'(SplitY + DividerHalf - 1);

   logic [9:0]  x_q, x_d;
   logic [8:0]  y_q, y_d;
   logic        blank_q, vs_q;
   logic [23:0] rgb_q, rgb_d;
   logic        frame_start, divider, lit_en;
   logic [1:0]  pad, lit_pad;
   logic        hs_unused;

   assign hs_unused = VGA_HS;

   always_ff @(posedge VGA_CLK) begin
      if (reset) begin
         x_q     <= '0;
         y_q     <= '0;
         blank_q <= 1'b0;
         vs_q    <= 1'b0;
         rgb_q   <= '0;
      end else begin
         x_q     <= x_d;
         y_q     <= y_d;
         blank_q <= VGA_BLANK_N;
         vs_q    <= VGA_VS;
         rgb_q   <= rgb_d;
      end
   end

   always_comb begin
      x_d = x_q;
      if (!VGA_BLANK_N)      x_d = '0;
      else if (x_q != '1)    x_d = x_q + 10'd1;

      // Rows advance at the end of each visible line.
      y_d = y_q;
      if (!VGA_VS)                                         y_d = '0;
      else if (blank_q && !VGA_BLANK_N && (y_q != '1))     y_d = y_q + 9'd1;

      frame_start = vs_q && !VGA_VS;
      pad         = {(y_q >= SplitYW), (x_q >= SplitXW)};
      divider     = ((x_q >= DivXLo) && (x_q <= DivXHi)) ||
                    ((y_q >= DivYLo) && (y_q <= DivYHi));

      rgb_d = '0;
      if (VGA_BLANK_N && !divider) rgb_d = pad_rgb(pad, lit_en && (lit_pad == pad));
   end

   assign {R, G, B} = rgb_q;

   genius_light_fsm u_light_fsm (
      .clk_i          (VGA_CLK),
      .reset_i        (reset),
      .frame_start_i  (frame_start),
      .light_req_i    (light_req),
      .light_color_i  (light_color),
      .light_frames_i (light_frames),
      .lit_en_o       (lit_en),
      .lit_pad_o      (lit_pad),
      .busy_o         (light_busy),
      .done_o         (light_done)
   );

endmodule

// File: tb/tb_genius_pixel_gen.sv
// Directed bench for genius_pixel_gen: drives compressed VGA frames and probes pad pixels.
module tb_genius_pixel_gen;

   logic       VGA_CLK = 1'b0;
   logic       reset = 1'b1;
   logic       VGA_HS = 1'b1;
   logic       VGA_VS = 1'b1;
   logic       VGA_BLANK_N = 1'b0;
   logic       light_req = 1'b0;
   logic [1:0] light_color = '0;
   logic [5:0] light_frames = '0;
   logic [7:0] R, G, B;
   logic       light_busy, light_done;

   int vectors = 0;
   int miscompares = 0;
   int done_cnt = 0;

   always #5 VGA_CLK = ~VGA_CLK;

   genius_pixel_gen dut (
      .VGA_CLK      (VGA_CLK),
      .reset        (reset),
      .VGA_HS       (VGA_HS),
      .VGA_VS       (VGA_VS),
      .VGA_BLANK_N  (VGA_BLANK_N),
      .light_req    (light_req),
      .light_color  (light_color),
      .light_frames (light_frames),
      .R            (R),
      .G            (G),
      .B            (B),
      .light_busy   (light_busy),
      .light_done   (light_done)
   );

   // Counts cycles with done high, so one pulse of one cycle adds exactly 1.
   always @(negedge VGA_CLK) if (light_done === 1'b1) done_cnt++;

   task automatic tick();
      @(posedge VGA_CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [23:0] exp_px(input int x, input int y, input int lit);
      int pad;
      if ((x >= 318 && x <= 321) || (y >= 238 && y <= 241)) return 24'h000000;
      pad = ((x >= 320) ? 1 : 0) + ((y >= 240) ? 2 : 0);
      case (pad)
         0:       return (lit == 0) ? 24'h00FF00 : 24'h004000;
         1:       return (lit == 1) ? 24'hFF0000 : 24'h400000;
         2:       return (lit == 2) ? 24'hFFFF00 : 24'h404000;
         default: return (lit == 3) ? 24'h0000FF : 24'h000040;
      endcase
   endfunction

   function automatic bit is_probe(input int x, input int y);
      return (y == 100 && (x == 100 || x == 500)) || (y == 400 && (x == 100 || x == 500)) ||
             (y == 50 && x == 319) || (y == 239 && x == 50);
   endfunction

   // One frame: VS pulse, then 410 lines; probed lines are 504 pixels wide, the rest 1 pixel.
   task automatic run_frame(input int lit);
      VGA_VS = 1'b0;
      tick();
      tick();
      VGA_VS = 1'b1;
      tick();
      tick();
      for (int r = 0; r < 410; r++) begin
         int w;
         w = (r == 50 || r == 100 || r == 239 || r == 400) ? 504 : 1;
         for (int i = 0; i < w; i++) begin
            VGA_BLANK_N = 1'b1;
            tick();
            if (is_probe(i, r))
               chk($sformatf("pix(%0d,%0d) lit=%0d", i, r, lit), {R, G, B}, exp_px(i, r, lit));
         end
         VGA_BLANK_N = 1'b0;
         tick();
         if (r == 100) chk("blank_rgb", {R, G, B}, 24'h000000);
         VGA_HS = 1'b0;
         tick();
         VGA_HS = 1'b1;
         tick();
      end
   endtask

   task automatic request(input logic [1:0] color, input logic [5:0] frames);
      light_req    = 1'b1;
      light_color  = color;
      light_frames = frames;
      tick();
      light_req = 1'b0;
   endtask

   initial begin
      // Reset state
      repeat (3) tick();
      chk("reset_rgb", {R, G, B}, 24'h000000);
      chk("reset_busy", {23'd0, light_busy}, 24'd0);
      chk("reset_done", {23'd0, light_done}, 24'd0);
      reset = 1'b0;
      tick();

      // Idle: all pads dim
      run_frame(-1);
      chk("idle_busy", {23'd0, light_busy}, 24'd0);

      // Red for 3 frames; a green request while lit is ignored
      request(2'd1, 6'd3);
      chk("req_busy", {23'd0, light_busy}, 24'd1);
      run_frame(1);
      request(2'd0, 6'd2);
      chk("lit_busy", {23'd0, light_busy}, 24'd1);
      run_frame(1);
      run_frame(1);
      chk("no_early_done", done_cnt[23:0], 24'd0);
      run_frame(-1);
      chk("red_done_cnt", done_cnt[23:0], 24'd1);
      chk("red_busy_drop", {23'd0, light_busy}, 24'd0);

      // frames=0 acts as 1 frame
      request(2'd3, 6'd0);
      run_frame(3);
      run_frame(-1);
      chk("blue_done_cnt", done_cnt[23:0], 24'd2);
      chk("blue_busy_drop", {23'd0, light_busy}, 24'd0);

      // Request held through DONE is re-accepted on the following idle cycle
      light_req    = 1'b1;
      light_color  = 2'd2;
      light_frames = 6'd1;
      tick();
      run_frame(2);
      run_frame(-1);
      light_req = 1'b0;
      chk("rearm_busy", {23'd0, light_busy}, 24'd1);
      chk("rearm_done_cnt", done_cnt[23:0], 24'd3);
      run_frame(2);
      run_frame(-1);
      chk("rearm_final_done", done_cnt[23:0], 24'd4);

      // Reset mid-LIT abandons the request silently
      request(2'd1, 6'd5);
      run_frame(1);
      reset = 1'b1;
      tick();
      chk("rst_busy", {23'd0, light_busy}, 24'd0);
      chk("rst_done", {23'd0, light_done}, 24'd0);
      chk("rst_rgb", {R, G, B}, 24'h000000);
      reset = 1'b0;
      tick();
      run_frame(-1);
      chk("rst_no_done", done_cnt[23:0], 24'd4);
      chk("rst_idle_busy", {23'd0, light_busy}, 24'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
